// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the packet-aware 1-to-2 stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PKT0,
        PKT1
    } route_state_t;

    localparam logic ROUTE_0 = 1'b0;
    localparam logic ROUTE_1 = 1'b1;

    // Mid-packet state that keeps the chosen route locked.
    function automatic route_state_t pkt_state(input logic route);
        return (route == ROUTE_1) ? PKT1 : PKT0;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register: accepts a new entry while its current one drains.
module stream_reg_slice #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    assign s_ready = !m_valid || m_ready;

    // Payload only changes on a load, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (s_valid && s_ready) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1x2.sv
// Packet-aware 1-to-2 stream demultiplexer: route chosen on a packet's first beat
// and held until its last beat; one registered slot and a delivered-beat counter per output.
module stream_demux_1x2
    import stream_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int unsigned SLOT_W = WIDTH + 1;

    route_state_t      state;
    route_state_t      state_nxt;
    logic              route;
    logic [1:0]        slot_ready;
    logic [1:0]        load;
    logic [SLOT_W-1:0] slot0_q;
    logic [SLOT_W-1:0] slot1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Route selection, input backpressure and packet tracking.
    always_comb begin
        state_nxt = state;
        route     = ROUTE_0;
        load      = 2'b00;
        unique case (state)
            IDLE:    route = in_sel;
            PKT0:    route = ROUTE_0;
            PKT1:    route = ROUTE_1;
            default: route = ROUTE_0;
        endcase
        in_ready = slot_ready[route];
        load[0]  = in_valid && (route == ROUTE_0);
        load[1]  = in_valid && (route == ROUTE_1);
        if (in_valid && in_ready) begin
            state_nxt = in_last ? IDLE : pkt_state(route);
        end
    end

    stream_reg_slice #(.W(SLOT_W)) u_slot0 (
        .clk     (clk),
        .reset   (reset),
        .s_valid (load[0]),
        .s_ready (slot_ready[0]),
        .s_data  ({in_last, in_data}),
        .m_valid (out0_valid),
        .m_ready (out0_ready),
        .m_data  (slot0_q)
    );

    stream_reg_slice #(.W(SLOT_W)) u_slot1 (
        .clk     (clk),
        .reset   (reset),
        .s_valid (load[1]),
        .s_ready (slot_ready[1]),
        .s_data  ({in_last, in_data}),
        .m_valid (out1_valid),
        .m_ready (out1_ready),
        .m_data  (slot1_q)
    );

    assign {out0_last, out0_data} = slot0_q;
    assign {out1_last, out1_data} = slot1_q;

    // Delivered-beat counters wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) cnt0 <= cnt0 + CNT_W'(1);
            if (out1_valid && out1_ready) cnt1 <= cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Bench for stream_demux_1x2: directed scenarios plus random traffic scored against
// a queue-based packet model; a second instance with 4-bit counters covers wrap-around.
module tb_stream_demux_1x2;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT_NW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_sel, in_last, in_valid;
    logic             out0_ready, out1_ready;

    logic             in_ready;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic             out0_last, out1_last, out0_valid, out1_valid;
    logic [CNT_W-1:0] cnt0, cnt1;

    logic              n_in_ready;
    logic [WIDTH-1:0]  n_out0_data, n_out1_data;
    logic              n_out0_last, n_out1_last, n_out0_valid, n_out1_valid;
    logic [CNT_NW-1:0] n_cnt0, n_cnt1;

    stream_demux_1x2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_last(out0_last), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_last(out1_last), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    stream_demux_1x2 #(.WIDTH(WIDTH), .CNT_W(CNT_NW)) dut_n (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .out0_data(n_out0_data), .out0_last(n_out0_last), .out0_valid(n_out0_valid), .out0_ready(out0_ready),
        .out1_data(n_out1_data), .out1_last(n_out1_last), .out1_valid(n_out1_valid), .out1_ready(out1_ready),
        .cnt0(n_cnt0), .cnt1(n_cnt1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-output queues of {last,data}, packet route lock, beat counts.
    logic [WIDTH:0]    slotq [2][$];
    bit                mid_pkt;
    bit                pkt_route;
    logic [CNT_W-1:0]  m_cnt [2];
    logic [CNT_NW-1:0] m_ncnt [2];
    bit                after_reset;

    function automatic void model_clear();
        slotq[0].delete();
        slotq[1].delete();
        mid_pkt   = 1'b0;
        pkt_route = 1'b0;
        for (int n = 0; n < 2; n++) begin
            m_cnt[n]  = '0;
            m_ncnt[n] = '0;
        end
    endfunction

    // One clock: check outputs at the falling edge, advance the model, cross the rising edge.
    task automatic step(output bit acc);
        bit route;
        bit exp_rdy;
        bit ordy [2];
        @(negedge clk);
        ordy[0] = out0_ready;
        ordy[1] = out1_ready;
        route   = mid_pkt ? pkt_route : in_sel;
        exp_rdy = (slotq[route].size() == 0) || ordy[route];
        check("in_ready", in_ready, exp_rdy);
        check("n_in_ready", n_in_ready, exp_rdy);
        check("out0_valid", out0_valid, slotq[0].size() != 0);
        check("out1_valid", out1_valid, slotq[1].size() != 0);
        if (slotq[0].size() != 0) check("out0_beat", {out0_last, out0_data}, slotq[0][0]);
        if (slotq[1].size() != 0) check("out1_beat", {out1_last, out1_data}, slotq[1][0]);
        if (after_reset) begin
            check("out0_reset_beat", {out0_last, out0_data}, 0);
            check("out1_reset_beat", {out1_last, out1_data}, 0);
        end
        check("cnt0", cnt0, m_cnt[0]);
        check("cnt1", cnt1, m_cnt[1]);
        check("n_cnt0", n_cnt0, m_ncnt[0]);
        check("n_cnt1", n_cnt1, m_ncnt[1]);

        acc = 1'b0;
        if (reset) begin
            model_clear();
            after_reset = 1'b1;
        end else begin
            after_reset = 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (slotq[n].size() != 0 && ordy[n]) begin
                    void'(slotq[n].pop_front());
                    m_cnt[n]  = m_cnt[n] + 1'b1;
                    m_ncnt[n] = m_ncnt[n] + 1'b1;
                end
            end
            if (in_valid && exp_rdy) begin
                acc = 1'b1;
                slotq[route].push_back({in_last, in_data});
                if (in_last) mid_pkt = 1'b0;
                else begin
                    mid_pkt   = 1'b1;
                    pkt_route = route;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(a);
    endtask

    // Present one beat and hold it until accepted, within a bounded number of cycles.
    task automatic send(input logic [7:0] d, input bit sel, input bit last);
        bit a;
        int waited;
        in_data  = d;
        in_sel   = sel;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        do begin
            step(a);
            waited++;
        end while (!a && waited < 50);
        if (!a) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        bit a;
        reset      = 1'b1;
        in_data    = '0;
        in_sel     = 1'b0;
        in_last    = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        after_reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        after_reset = 1'b1;
        step(a);
        reset = 1'b0;

        // Single-beat packet to out1.
        send(8'hA5, 1'b1, 1'b1);
        idle(3);

        // Three-beat packet whose sel flips mid-packet stays on out0.
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b1);
        idle(2);
        send(8'h44, 1'b1, 1'b1);
        idle(2);

        // Stalled out0: second beat backpressured until the sink resumes.
        out0_ready = 1'b0;
        send(8'h55, 1'b0, 1'b0);
        in_data = 8'h66; in_sel = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step(a);
        out0_ready = 1'b1;
        send(8'h66, 1'b0, 1'b1);
        idle(3);

        // out1 traffic flows while out0 is held.
        out0_ready = 1'b0;
        send(8'h77, 1'b0, 1'b1);
        send(8'h81, 1'b1, 1'b0);
        send(8'h82, 1'b0, 1'b1);
        idle(3);
        out0_ready = 1'b1;
        idle(2);

        // Reset in the middle of a packet routed to out1.
        out1_ready = 1'b0;
        send(8'h91, 1'b1, 1'b0);
        reset = 1'b1;
        step(a);
        reset = 1'b0;
        out1_ready = 1'b1;
        send(8'h92, 1'b0, 1'b1);
        idle(2);

        // 17 single-beat packets to out0 wrap the 4-bit counter.
        for (int i = 0; i < 17; i++) send(8'(i), 1'b0, 1'b1);
        idle(2);

        // Random traffic with random sink stalls and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            in_data    = 8'($urandom);
            in_sel     = 1'($urandom);
            in_last    = ($urandom_range(0, 2) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            reset      = ($urandom_range(0, 199) == 0);
            step(a);
        end
        reset = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
